seg_display_arbiter: RTL and testbench



---
 rtl/seg_display_arbiter.sv | 163 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Round-robin time-sharing of the 8-digit seven-segment debug display among
//   NREQ debug sources. The granted source's 32-bit value drives hex1..hex8.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   req       per-source request, level-sensitive
//   data      packed source values, source i at data[32*i +: 32]
//   lock      freezes the dwell counter and suppresses rotation
//   grant     one-hot current owner, zero when idle
//   owner_id  index of current owner, 0 when idle
//   busy      high while a source is granted
//   hex1..8   display nibbles, hex1 = disp[3:0] ... hex8 = disp[31:28]
module seg_display_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   data,
    input  logic                 lock,
    output logic [NREQ-1:0]      grant,
    output logic [2:0]           owner_id,
    output logic                 busy,
    output logic [3:0]           hex1,
    output logic [3:0]           hex2,
    output logic [3:0]           hex3,
    output logic [3:0]           hex4,
    output logic [3:0]           hex5,
    output logic [3:0]           hex6,
    output logic [3:0]           hex7,
    output logic [3:0]           hex8
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] DwellMax = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {StIdle, StShow} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, last_d;     // round-robin pointer, equals owner while showing
    logic [2:0]        owner_id_q, owner_id_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;
    logic [31:0]       disp_q, disp_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;

    logic [31:0]       src [NREQ];
    logic [IdxW-1:0]   pick, cand;
    logic              pick_vld;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            src[i] = data[32*i +: 32];
        end
    end

    // First requester after last_q, wrapping; may return last_q itself.
    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdxW'((32'(last_q) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_id_d = owner_id_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        disp_d     = disp_q;
        dwell_d    = dwell_q;

        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d    = StShow;
                    last_d     = pick;
                    owner_id_d = 3'(pick);
                    grant_d    = NREQ'(1) << pick;
                    busy_d     = 1'b1;
                    disp_d     = src[pick];
                    dwell_d    = '0;
                end
            end
            StShow: begin
                if (!req[last_q]) begin
                    // Release wins over lock.
                    if (pick_vld) begin
                        last_d     = pick;
                        owner_id_d = 3'(pick);
                        grant_d    = NREQ'(1) << pick;
                        disp_d     = src[pick];
                        dwell_d    = '0;
                    end else begin
                        state_d    = StIdle;
                        owner_id_d = '0;
                        grant_d    = '0;
                        busy_d     = 1'b0;
                        disp_d     = '0;
                        dwell_d    = '0;
                    end
                end else if (lock) begin
                    disp_d = src[last_q];
                end else if (dwell_q == DwellMax) begin
                    // pick equals the owner when nobody else is waiting.
                    last_d     = pick;
                    owner_id_d = 3'(pick);
                    grant_d    = NREQ'(1) << pick;
                    disp_d     = src[pick];
                    dwell_d    = '0;
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                    disp_d  = src[last_q];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_q     <= IdxW'(NREQ - 1);
            owner_id_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            disp_q     <= '0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_id_q <= owner_id_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            disp_q     <= disp_d;
            dwell_q    <= dwell_d;
        end
    end

    assign grant    = grant_q;
    assign owner_id = owner_id_q;
    assign busy     = busy_q;
    assign hex1     = disp_q[3:0];
    assign hex2     = disp_q[7:4];
    assign hex3     = disp_q[11:8];
    assign hex4     = disp_q[15:12];
    assign hex5     = disp_q[19:16];
    assign hex6     = disp_q[23:20];
    assign hex7     = disp_q[27:24];
    assign hex8     = disp_q[31:28];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NREQ=4, HOLD_CYCLES=8.
module tb_seg_display_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned HOLD = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [127:0]    data;
    logic            lock;
    logic [3:0]      grant;
    logic [2:0]      owner_id;
    logic            busy;
    logic [3:0]      hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8;
    logic [31:0]     hexall;

    int total = 0;
    int bad   = 0;

    logic [31:0] vals [4];
    int unsigned seq  [3];
    int unsigned own;

    seg_display_arbiter #(
        .NREQ        (NREQ),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data     (data),
        .lock     (lock),
        .grant    (grant),
        .owner_id (owner_id),
        .busy     (busy),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .hex6     (hex6),
        .hex7     (hex7),
        .hex8     (hex8)
    );

    always #5 clk = ~clk;

    assign hexall = {hex8, hex7, hex6, hex5, hex4, hex3, hex2, hex1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        data = '0;
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner_id), 32'h0);
        check("rst_hex", hexall, 32'h0);

        // 1: single requester
        data[31:0] = 32'h1234_5678;
        req = 4'b0001;
        step();
        check("s1_grant", 32'(grant), 32'h1);
        check("s1_busy", 32'(busy), 32'h1);
        check("s1_hex", hexall, 32'h1234_5678);
        check("s1_hex8", 32'(hex8), 32'h1);
        check("s1_hex1", 32'(hex1), 32'h8);
        for (int i = 0; i < 20; i++) step();
        check("s1_hold_grant", 32'(grant), 32'h1);
        check("s1_hold_owner", 32'(owner_id), 32'h0);

        // 2: rotation among 0,1,3
        do_reset();
        vals[0] = 32'hA0A0_A0A0;
        vals[1] = 32'hB1B1_B1B1;
        vals[2] = 32'h0000_0000;
        vals[3] = 32'hD3D3_D3D3;
        for (int i = 0; i < 4; i++) data[32*i +: 32] = vals[i];
        seq[0] = 0;
        seq[1] = 1;
        seq[2] = 3;
        req = 4'b1011;
        for (int n = 1; n <= 26; n++) begin
            step();
            own = seq[((n - 1) / HOLD) % 3];
            check($sformatf("s2_grant_%0d", n), 32'(grant), 32'(4'b0001 << own));
            check($sformatf("s2_hex_%0d", n), hexall, vals[own]);
        end

        // 3: owner release, then release to idle
        do_reset();
        req = 4'b0011;
        for (int n = 1; n <= 12; n++) step();  // owner 1 since edge 9, dwell 3
        check("s3_pre_grant", 32'(grant), 32'h2);
        req = 4'b1001;
        step();                                 // edge 13
        check("s3_rel_grant", 32'(grant), 32'h8);
        check("s3_rel_owner", 32'(owner_id), 32'h3);
        for (int n = 14; n <= 20; n++) step();
        check("s3_dwell_full", 32'(grant), 32'h8);
        step();                                 // edge 21
        check("s3_dwell_exp", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        check("s3_idle_grant", 32'(grant), 32'h0);
        check("s3_idle_busy", 32'(busy), 32'h0);
        check("s3_idle_hex", hexall, 32'h0);
        check("s3_idle_owner", 32'(owner_id), 32'h0);

        // 4: lock freezes rotation
        do_reset();
        req = 4'b0011;
        for (int n = 1; n <= 3; n++) step();    // owner 0, dwell 2
        lock = 1'b1;
        for (int n = 0; n < 30; n++) begin
            step();
            check($sformatf("s4_lock_%0d", n), 32'(grant), 32'h1);
        end
        lock = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            check($sformatf("s4_rem_%0d", n), 32'(grant), 32'h1);
        end
        step();
        check("s4_rotate", 32'(grant), 32'h2);

        // 5: live data tracking
        do_reset();
        data[31:0] = 32'hDEAD_BEEF;
        req = 4'b0001;
        step();
        check("s5_first", hexall, 32'hDEAD_BEEF);
        step();
        step();
        data[31:0] = 32'hCAFE_F00D;
        #1;
        check("s5_before_edge", hexall, 32'hDEAD_BEEF);
        step();
        check("s5_after_edge", hexall, 32'hCAFE_F00D);
        check("s5_grant", 32'(grant), 32'h1);

        // 6: asynchronous reset mid-show
        do_reset();
        data[31:0] = 32'h1111_1111;
        req = 4'b0011;
        step();
        step();
        check("s6_pre_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #2;
        check("s6_async_grant", 32'(grant), 32'h0);
        check("s6_async_busy", 32'(busy), 32'h0);
        check("s6_async_hex", hexall, 32'h0);
        check("s6_async_owner", 32'(owner_id), 32'h0);
        req = 4'b1100;
        step();
        rst_n = 1'b1;
        step();
        check("s6_first_grant", 32'(grant), 32'h4);
        check("s6_first_owner", 32'(owner_id), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
